pipe_trace_monitor: RTL and testbench

Synthesizable, parametrised successor to the pipeline observation harness. Sits beside the 5-stage core and watches the WB retire stream plus the ID stall and flush indications. Keeps saturating performance counters and stores retired instructions in an on-chip trace FIFO. The FIFO is drained over a valid/ready port. Supports fill-stop, wrap-around and PC-triggered capture modes.

---
 rtl/trace_pkg.sv | 30 +++
 rtl/pipe_trace_monitor_fifo.sv | 72 +++++++
 rtl/pipe_trace_monitor.sv | 161 ++++++++++++++++
 tb/tb_pipe_trace_monitor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the pipeline trace monitor: trace entry layout, capture modes and FSM states.
package trace_pkg;

  localparam int TRACE_XLEN    = 32;
  localparam int TRACE_RADDR_W = 5;

  // Default-width view of one trace record; the top builds the same layout from its parameters.
  typedef struct packed {
    logic [TRACE_XLEN-1:0]    pc;
    logic [TRACE_XLEN-1:0]    instr;
    logic [TRACE_RADDR_W-1:0] rd;
    logic                     we;
    logic [TRACE_XLEN-1:0]    data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_FILL = 2'd1,
    MODE_WRAP = 2'd2,
    MODE_TRIG = 2'd3
  } mon_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_STOPPED = 2'd3
  } mon_state_e;

endpackage

// File: rtl/pipe_trace_monitor_fifo.sv
// First-word-fall-through trace FIFO; when full, a lone push either is rejected or,
// with wrap set, overwrites the oldest entry.
module trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic             wrap,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             dropped,
  output logic             overwrote
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_pop_s;
  logic             do_push_s;
  logic             blocked_s;

  // Classify this cycle's push/pop against the current occupancy.
  always_comb begin
    full      = (count_r == CW'(DEPTH));
    do_pop_s  = pop && (count_r != '0);
    blocked_s = push && full && !do_pop_s;
    overwrote = blocked_s && wrap;
    dropped   = blocked_s && !wrap;
    do_push_s = push && !dropped;
  end

  // Pointer and occupancy registers; an overwrite moves both pointers and keeps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s || overwrote) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s && !overwrote, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push_s && !clr) mem_r[wr_ptr_r] <= din;
  end

  assign head  = mem_r[rd_ptr_r];
  assign valid = (count_r != '0);
  assign count = count_r;

endmodule

// File: rtl/pipe_trace_monitor.sv
// Pipeline trace monitor: watches the WB retire stream, keeps saturating performance
// counters and captures retired instructions into a drainable trace FIFO.
module pipe_trace_monitor
  import trace_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_W       = 32,
  parameter int RADDR_W     = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic [XLEN-1:0]              trig_pc,
  input  logic                         clear,
  input  logic                         wb_isValid,
  input  logic [XLEN-1:0]              wb_pc,
  input  logic [XLEN-1:0]              wb_instr,
  input  logic [RADDR_W-1:0]           wb_rd,
  input  logic                         wb_regWrite,
  input  logic [XLEN-1:0]              wb_data,
  input  logic                         id_stall,
  input  logic                         flush,
  output logic                         tr_valid,
  input  logic                         tr_ready,
  output logic [XLEN-1:0]              tr_pc,
  output logic [XLEN-1:0]              tr_instr,
  output logic [XLEN-1:0]              tr_data,
  output logic [RADDR_W-1:0]           tr_rd,
  output logic                         tr_we,
  output logic [$clog2(TRACE_DEPTH):0] tr_count,
  output logic [CNT_W-1:0]             cyc_cnt,
  output logic [CNT_W-1:0]             ret_cnt,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             flush_cnt,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic                         overflow,
  output logic                         trig_hit,
  output logic [1:0]                   state_out
);

  localparam int CW = $clog2(TRACE_DEPTH) + 1;
  localparam logic [CW-1:0] NEAR_FULL_C = CW'(TRACE_DEPTH - 1);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    instr;
    logic [RADDR_W-1:0] rd;
    logic               we;
    logic [XLEN-1:0]    data;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    else return v;
  endfunction

  mon_state_e state_r, state_nx_s;
  mon_mode_e  mode_s;
  entry_t     push_entry_s, head_s;
  logic       active_s, trig_s, push_req_s, do_pop_s, fill_mode_s;
  logic       fifo_valid_s, fifo_full_s, fifo_drop_s, fifo_ovw_s;
  logic [CW-1:0] fifo_count_s;

  assign mode_s       = mon_mode_e'(mode);
  assign active_s     = enable && (mode_s != MODE_OFF);
  assign fill_mode_s  = (mode_s == MODE_FILL) || (mode_s == MODE_TRIG);
  assign trig_s       = active_s && (state_r == ST_ARMED) && wb_isValid && (wb_pc == trig_pc);
  // STOPPED still presents retires to the FIFO so rejected pushes are counted as drops.
  assign push_req_s   = active_s && wb_isValid &&
                        ((state_r == ST_CAPTURE) || (state_r == ST_STOPPED) || trig_s);
  assign do_pop_s     = tr_ready && fifo_valid_s;
  assign push_entry_s = '{pc: wb_pc, instr: wb_instr, rd: wb_rd, we: wb_regWrite, data: wb_data};

  trace_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (clear),
    .push      (push_req_s),
    .pop       (tr_ready),
    .wrap      (mode_s == MODE_WRAP),
    .din       (push_entry_s),
    .head      (head_s),
    .valid     (fifo_valid_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .dropped   (fifo_drop_s),
    .overwrote (fifo_ovw_s)
  );

  // Next-state logic: clear first, then disable, then per-state capture control.
  always_comb begin
    state_nx_s = state_r;
    if (clear) begin
      state_nx_s = (enable && (mode_s == MODE_TRIG)) ? ST_ARMED : ST_IDLE;
    end else if (!active_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    state_nx_s = (mode_s == MODE_TRIG) ? ST_ARMED : ST_CAPTURE;
        ST_ARMED:   state_nx_s = trig_s ? ST_CAPTURE : ST_ARMED;
        ST_CAPTURE: state_nx_s = (fill_mode_s && push_req_s && !do_pop_s &&
                                  (fifo_count_s >= NEAR_FULL_C)) ? ST_STOPPED : ST_CAPTURE;
        ST_STOPPED: state_nx_s = fifo_full_s ? ST_STOPPED : ST_CAPTURE;
        default:    state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Saturating performance counters and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt   <= '0;
      ret_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      trig_hit  <= 1'b0;
    end else if (clear) begin
      cyc_cnt   <= '0;
      ret_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      trig_hit  <= 1'b0;
    end else if (enable) begin
      cyc_cnt   <= sat_inc(cyc_cnt, 1'b1);
      ret_cnt   <= sat_inc(ret_cnt, wb_isValid);
      stall_cnt <= sat_inc(stall_cnt, id_stall);
      flush_cnt <= sat_inc(flush_cnt, flush);
      drop_cnt  <= sat_inc(drop_cnt, fifo_drop_s);
      overflow  <= overflow | fifo_ovw_s;
      trig_hit  <= trig_hit | trig_s;
    end else begin
      overflow  <= overflow;
      trig_hit  <= trig_hit;
    end
  end

  assign tr_valid  = fifo_valid_s;
  assign tr_count  = fifo_count_s;
  assign tr_pc     = fifo_valid_s ? head_s.pc    : '0;
  assign tr_instr  = fifo_valid_s ? head_s.instr : '0;
  assign tr_data   = fifo_valid_s ? head_s.data  : '0;
  assign tr_rd     = fifo_valid_s ? head_s.rd    : '0;
  assign tr_we     = fifo_valid_s ? head_s.we    : 1'b0;
  assign state_out = state_r;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Scoreboard bench for pipe_trace_monitor: expected trace entries are queued as retires are
// driven and compared as the FIFO is drained; a CNT_W=4 instance covers counter saturation.
module tb_pipe_trace_monitor;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, clear = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] trig_pc = 32'd0, wb_pc = 32'd0, wb_instr = 32'd0, wb_data = 32'd0;
  logic [4:0]  wb_rd = 5'd0;
  logic        wb_isValid = 1'b0, wb_regWrite = 1'b0, id_stall = 1'b0, flush = 1'b0;
  logic        tr_ready = 1'b0;

  logic        tr_valid, tr_we, overflow, trig_hit;
  logic [31:0] tr_pc, tr_instr, tr_data;
  logic [4:0]  tr_rd;
  logic [4:0]  tr_count;
  logic [31:0] cyc_cnt, ret_cnt, stall_cnt, flush_cnt, drop_cnt;
  logic [1:0]  state_out;

  logic        c4_valid, c4_we, c4_overflow, c4_trig_hit;
  logic [31:0] c4_pc, c4_instr, c4_data;
  logic [4:0]  c4_rd;
  logic [4:0]  c4_count;
  logic [3:0]  c4_cyc, c4_ret, c4_stall, c4_flush, c4_drop;
  logic [1:0]  c4_state;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_trace_monitor dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .trig_pc(trig_pc), .clear(clear),
    .wb_isValid(wb_isValid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_rd(wb_rd),
    .wb_regWrite(wb_regWrite), .wb_data(wb_data), .id_stall(id_stall), .flush(flush),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_instr(tr_instr),
    .tr_data(tr_data), .tr_rd(tr_rd), .tr_we(tr_we), .tr_count(tr_count),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .drop_cnt(drop_cnt), .overflow(overflow), .trig_hit(trig_hit), .state_out(state_out)
  );

  pipe_trace_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .trig_pc(trig_pc), .clear(clear),
    .wb_isValid(wb_isValid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_rd(wb_rd),
    .wb_regWrite(wb_regWrite), .wb_data(wb_data), .id_stall(id_stall), .flush(flush),
    .tr_valid(c4_valid), .tr_ready(tr_ready), .tr_pc(c4_pc), .tr_instr(c4_instr),
    .tr_data(c4_data), .tr_rd(c4_rd), .tr_we(c4_we), .tr_count(c4_count),
    .cyc_cnt(c4_cyc), .ret_cnt(c4_ret), .stall_cnt(c4_stall), .flush_cnt(c4_flush),
    .drop_cnt(c4_drop), .overflow(c4_overflow), .trig_hit(c4_trig_hit), .state_out(c4_state)
  );

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t r;
    r.pc    = pc;
    r.instr = pc ^ 32'hA5A5_0000;
    r.rd    = pc[6:2];
    r.we    = pc[2];
    r.data  = pc + 32'd100;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc);
    exp_t r;
    r = mk(pc);
    wb_isValid = 1'b1; wb_pc = r.pc; wb_instr = r.instr;
    wb_rd = r.rd; wb_regWrite = r.we; wb_data = r.data;
    tick;
    wb_isValid = 1'b0;
  endtask

  task automatic do_clear(input logic [1:0] m, input logic en);
    mode = m; enable = en; clear = 1'b1;
    tick;
    clear = 1'b0;
    q.delete();
  endtask

  task automatic test_reset;
    tick; tick;
    n_cmp++;
    if ({tr_valid, tr_count, cyc_cnt, drop_cnt, state_out, tr_pc} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b count=%0d cyc=%0d drop=%0d state=%0d pc=%h, expected all 0",
               tr_valid, tr_count, cyc_cnt, drop_cnt, state_out, tr_pc);
    end
    reset = 1'b1;
    do_clear(2'd1, 1'b1);
    tick;
    for (int i = 0; i < 5; i++) retire(32'h10 + 32'(i * 4));
    n_cmp++;
    if (tr_count !== 5'd5) begin
      n_bad++; $display("FAIL pre_reset_count: got %0d expected 5", tr_count);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({tr_valid, tr_count, cyc_cnt, ret_cnt, state_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_capture: valid=%b count=%0d cyc=%0d ret=%0d state=%0d, expected all 0",
               tr_valid, tr_count, cyc_cnt, ret_cnt, state_out);
    end
    reset = 1'b1;
    q.delete();
  endtask

  task automatic test_fill_stop;
    do_clear(2'd1, 1'b1);
    tick;
    n_cmp++;
    if (state_out !== 2'd2) begin
      n_bad++; $display("FAIL fill_start_state: got %0d expected 2", state_out);
    end
    for (int i = 0; i < 20; i++) begin
      if (i < 16) q.push_back(mk(32'h100 + 32'(i * 4)));
      retire(32'h100 + 32'(i * 4));
    end
    n_cmp++;
    if (tr_count !== 5'd16 || drop_cnt !== 32'd4 || state_out !== 2'd3 || ret_cnt !== 32'd20) begin
      n_bad++;
      $display("FAIL fill_stop: count=%0d drop=%0d state=%0d ret=%0d, expected 16/4/3/20",
               tr_count, drop_cnt, state_out, ret_cnt);
    end
    e = q.pop_front();
    n_cmp++;
    if (tr_valid !== 1'b1 || tr_pc !== e.pc) begin
      n_bad++; $display("FAIL fill_first_head: valid=%b pc=%h expected pc=%h", tr_valid, tr_pc, e.pc);
    end
    tr_ready = 1'b1; tick; tr_ready = 1'b0;
    tick;
    n_cmp++;
    if (state_out !== 2'd2 || tr_count !== 5'd15) begin
      n_bad++; $display("FAIL fill_resume: state=%0d count=%0d expected 2/15", state_out, tr_count);
    end
  endtask

  task automatic test_back_to_back;
    q.push_back(mk(32'h200));
    retire(32'h200);
    n_cmp++;
    if (tr_count !== 5'd16 || state_out !== 2'd3) begin
      n_bad++; $display("FAIL refill: count=%0d state=%0d expected 16/3", tr_count, state_out);
    end
    e = q.pop_front();
    n_cmp++;
    if (tr_pc !== e.pc) begin
      n_bad++; $display("FAIL pushpop_head: got pc=%h expected %h", tr_pc, e.pc);
    end
    q.push_back(mk(32'h204));
    tr_ready = 1'b1;
    retire(32'h204);
    tr_ready = 1'b0;
    n_cmp++;
    if (tr_count !== 5'd16 || drop_cnt !== 32'd4) begin
      n_bad++; $display("FAIL full_pushpop: count=%0d drop=%0d expected 16/4", tr_count, drop_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      e = q.pop_front();
      n_cmp++;
      if (tr_valid !== 1'b1 || {tr_pc, tr_instr, tr_rd, tr_we, tr_data} !== {e.pc, e.instr, e.rd, e.we, e.data}) begin
        n_bad++;
        $display("FAIL b2b_drain[%0d]: valid=%b pc=%h instr=%h rd=%0d we=%b data=%h expected pc=%h instr=%h rd=%0d we=%b data=%h",
                 i, tr_valid, tr_pc, tr_instr, tr_rd, tr_we, tr_data, e.pc, e.instr, e.rd, e.we, e.data);
      end
      tr_ready = 1'b1; tick; tr_ready = 1'b0;
    end
    n_cmp++;
    if (tr_valid !== 1'b0 || tr_count !== 5'd0) begin
      n_bad++; $display("FAIL b2b_empty: valid=%b count=%0d expected 0/0", tr_valid, tr_count);
    end
  endtask

  task automatic test_wrap;
    do_clear(2'd2, 1'b1);
    tick;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 16) void'(q.pop_front());
      q.push_back(mk(32'(i * 4)));
      retire(32'(i * 4));
    end
    n_cmp++;
    if (overflow !== 1'b1 || tr_count !== 5'd16 || tr_pc !== 32'd16 || state_out !== 2'd2) begin
      n_bad++;
      $display("FAIL wrap: overflow=%b count=%0d head=%0d state=%0d expected 1/16/16/2",
               overflow, tr_count, tr_pc, state_out);
    end
    for (int i = 0; i < 16; i++) begin
      e = q.pop_front();
      n_cmp++;
      if (tr_valid !== 1'b1 || {tr_pc, tr_instr, tr_rd, tr_we, tr_data} !== {e.pc, e.instr, e.rd, e.we, e.data}) begin
        n_bad++;
        $display("FAIL wrap_drain[%0d]: valid=%b pc=%h data=%h expected pc=%h data=%h",
                 i, tr_valid, tr_pc, tr_data, e.pc, e.data);
      end
      tr_ready = 1'b1; tick; tr_ready = 1'b0;
    end
  endtask

  task automatic test_trigger;
    trig_pc = 32'h40;
    do_clear(2'd3, 1'b1);
    n_cmp++;
    if (state_out !== 2'd1) begin
      n_bad++; $display("FAIL armed_after_clear: got %0d expected 1", state_out);
    end
    for (int i = 0; i < 9; i++) begin
      if (32'h30 + 32'(i * 4) >= 32'h40) q.push_back(mk(32'h30 + 32'(i * 4)));
      retire(32'h30 + 32'(i * 4));
      if (i == 3) begin
        n_cmp++;
        if (trig_hit !== 1'b0 || tr_count !== 5'd0) begin
          n_bad++; $display("FAIL pre_trigger: trig_hit=%b count=%0d expected 0/0", trig_hit, tr_count);
        end
      end
    end
    n_cmp++;
    if (trig_hit !== 1'b1 || ret_cnt !== 32'd9 || tr_count !== 5'd5 || state_out !== 2'd2) begin
      n_bad++;
      $display("FAIL trigger: trig_hit=%b ret=%0d count=%0d state=%0d expected 1/9/5/2",
               trig_hit, ret_cnt, tr_count, state_out);
    end
    for (int i = 0; i < 5; i++) begin
      e = q.pop_front();
      n_cmp++;
      if (tr_valid !== 1'b1 || tr_pc !== e.pc || tr_instr !== e.instr) begin
        n_bad++; $display("FAIL trig_drain[%0d]: pc=%h expected %h", i, tr_pc, e.pc);
      end
      tr_ready = 1'b1; tick; tr_ready = 1'b0;
    end
  endtask

  task automatic test_saturation;
    do_clear(2'd1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      id_stall = 1'b1;
      flush = (i < 3) ? 1'b1 : 1'b0;
      tick;
    end
    id_stall = 1'b0; flush = 1'b0;
    n_cmp++;
    if (c4_stall !== 4'd15 || stall_cnt !== 32'd20 || flush_cnt !== 32'd3 || c4_cyc !== 4'd15) begin
      n_bad++;
      $display("FAIL saturate: c4_stall=%0d stall=%0d flush=%0d c4_cyc=%0d expected 15/20/3/15",
               c4_stall, stall_cnt, flush_cnt, c4_cyc);
    end
    clear = 1'b1;
    retire(32'h300);
    clear = 1'b0;
    n_cmp++;
    if ({cyc_cnt, ret_cnt, stall_cnt, flush_cnt, tr_count, c4_stall, c4_cyc} !== '0) begin
      n_bad++;
      $display("FAIL clear_priority: cyc=%0d ret=%0d stall=%0d flush=%0d count=%0d c4_stall=%0d expected all 0",
               cyc_cnt, ret_cnt, stall_cnt, flush_cnt, tr_count, c4_stall);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_fill_stop;
    test_back_to_back;
    test_wrap;
    test_trigger;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
